// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, next-PC
// select encoding and the default sequential PC increment.
package cpu_pkg;

    // Default sequential PC increment, in bytes.
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } pc_state_e;

    // Next-PC source decided in EXECUTE and applied in WRITEBACK.
    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        TGT  = 2'd1,
        HOLD = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer producing the next-PC.
//
// The external PC register loads pc_next on every clock, so pc_next
// recirculates pc_cur except in WRITEBACK, where the committed value is
// applied.
//
// Ports:
//   clk, arst_n               clock, asynchronous active-low reset
//   start                     leave IDLE when high
//   pc_cur                    current PC from the PC register
//   imem_req / imem_ready     instruction fetch handshake
//   is_branch, is_jump,
//   is_halt, writes_rd        decoder flags (valid from DECODE)
//   branch_taken,
//   branch_target,
//   jump_target               ALU/decoder results (sampled at end of EXECUTE)
//   pc_next                   to PC register input
//   ir_load                   latch instruction register
//   rf_we                     register-file write enable
//   state_o                   current state encoding
//   halted                    high in HALT
//   misalign_err              sticky misaligned-target error
//   instret                   retired-instruction count
module pc_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_STEP    = cpu_pkg::PC_STEP
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pc_cur,
    output logic                  imem_req,
    input  logic                  imem_ready,
    input  logic                  is_branch,
    input  logic                  is_jump,
    input  logic                  is_halt,
    input  logic                  writes_rd,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic [DATA_WIDTH-1:0] jump_target,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic                  ir_load,
    output logic                  rf_we,
    output logic [2:0]            state_o,
    output logic                  halted,
    output logic                  misalign_err,
    output logic [DATA_WIDTH-1:0] instret
);
    import cpu_pkg::*;

    pc_state_e             state_q, state_d;
    pc_sel_e               sel_q, sel_d;
    logic [DATA_WIDTH-1:0] tgt_q, tgt_d;
    logic                  misal_q, misal_d;
    logic                  misalign_err_q, misalign_err_d;
    logic [DATA_WIDTH-1:0] instret_q, instret_d;

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start) state_d = FETCH;
            FETCH:     if (imem_ready) state_d = DECODE;
            DECODE:    state_d = EXECUTE;
            EXECUTE:   state_d = WRITEBACK;
            WRITEBACK: state_d = (misal_q || sel_q == HOLD) ? HALT : FETCH;
            HALT:      state_d = HALT;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        imem_req = (state_q == FETCH);
        ir_load  = (state_q == FETCH) && imem_ready;
        rf_we    = (state_q == WRITEBACK) && writes_rd && (sel_q != HOLD) && !misal_q;
        halted   = (state_q == HALT);
        pc_next  = pc_cur;
        if (state_q == WRITEBACK && !misal_q) begin
            unique case (sel_q)
                SEQ:     pc_next = pc_cur + DATA_WIDTH'(PC_STEP);
                TGT:     pc_next = tgt_q;
                default: pc_next = pc_cur;
            endcase
        end
    end

    assign state_o = state_q;

    // Decision/commit datapath next-state.
    always_comb begin
        sel_d          = sel_q;
        tgt_d          = tgt_q;
        misal_d        = misal_q;
        misalign_err_d = misalign_err_q;
        instret_d      = instret_q;
        if (state_q == EXECUTE) begin
            // Priority: halt > jump > taken branch > sequential.
            if (is_halt) begin
                sel_d = HOLD;
                tgt_d = '0;
            end else if (is_jump) begin
                sel_d = TGT;
                tgt_d = jump_target;
            end else if (is_branch && branch_taken) begin
                sel_d = TGT;
                tgt_d = branch_target;
            end else begin
                sel_d = SEQ;
                tgt_d = '0;
            end
            misal_d = (sel_d == TGT) && (tgt_d[1:0] != 2'b00);
        end
        if (state_q == WRITEBACK) begin
            // A misaligned target aborts the instruction without retiring it.
            if (misal_q) begin
                misalign_err_d = 1'b1;
            end else begin
                instret_d = instret_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sel_q          <= SEQ;
            tgt_q          <= '0;
            misal_q        <= 1'b0;
            misalign_err_q <= 1'b0;
            instret_q      <= '0;
        end else begin
            sel_q          <= sel_d;
            tgt_q          <= tgt_d;
            misal_q        <= misal_d;
            misalign_err_q <= misalign_err_d;
            instret_q      <= instret_d;
        end
    end

    assign misalign_err = misalign_err_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register and a
// scoreboard of per-instruction expectations.
module tb_pc_sequencer;
    import cpu_pkg::*;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [31:0] pc;
    logic        imem_req;
    logic        imem_ready;
    logic        is_branch;
    logic        is_jump;
    logic        is_halt;
    logic        writes_rd;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] pc_next;
    logic        ir_load;
    logic        rf_we;
    logic [2:0]  state_o;
    logic        halted;
    logic        misalign_err;
    logic [31:0] instret;

    pc_sequencer #(
        .DATA_WIDTH(32),
        .PC_STEP   (4)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .start        (start),
        .pc_cur       (pc),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .is_branch    (is_branch),
        .is_jump      (is_jump),
        .is_halt      (is_halt),
        .writes_rd    (writes_rd),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .pc_next      (pc_next),
        .ir_load      (ir_load),
        .rf_we        (rf_we),
        .state_o      (state_o),
        .halted       (halted),
        .misalign_err (misalign_err),
        .instret      (instret)
    );

    // Program counter register, loading every clock.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) pc <= '0;
        else         pc <= pc_next;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic        rfwe;
        int          cycles;
        logic [2:0]  end_state;
    } exp_t;

    exp_t        sb[$];
    int          npass = 0;
    int          ntotal = 0;
    logic [31:0] model_instret;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; expected results are queued
    // on entry and compared once WRITEBACK has completed.
    task automatic run_instr(input string tag, input logic br, input logic jmp,
                             input logic hlt, input logic wrd, input logic taken,
                             input logic [31:0] btgt, input logic [31:0] jtgt,
                             input int waits, input logic [31:0] exp_pc,
                             input logic exp_rfwe, input logic retire,
                             input logic [2:0] exp_end);
        exp_t        e;
        int          cycles;
        int          wait_left;
        logic        seen_rfwe;
        logic        done;
        logic [2:0]  st;
        logic [31:0] pc0;
        if (retire) model_instret = model_instret + 1;
        e.pc        = exp_pc;
        e.instret   = model_instret;
        e.rfwe      = exp_rfwe;
        e.cycles    = 4 + waits;
        e.end_state = exp_end;
        sb.push_back(e);

        check({tag, "/in_fetch"}, 32'(state_o), 32'(FETCH));
        pc0           = pc;
        is_branch     = br;
        is_jump       = jmp;
        is_halt       = hlt;
        writes_rd     = wrd;
        branch_taken  = taken;
        branch_target = btgt;
        jump_target   = jtgt;
        wait_left     = waits;
        imem_ready    = (waits == 0);
        cycles        = 0;
        seen_rfwe     = 1'b0;
        done          = 1'b0;
        #1;
        for (int k = 0; k < 40 && !done; k++) begin
            st = state_o;
            if (st == FETCH && wait_left > 0) begin
                check({tag, "/req_wait"}, 32'(imem_req), 32'd1);
                check({tag, "/pc_wait"}, pc, pc0);
            end
            if (st == FETCH && wait_left == 0) check({tag, "/ir_load"}, 32'(ir_load), 32'd1);
            if (st == WRITEBACK) begin
                seen_rfwe     = rf_we;
                // Late ALU changes must not affect the committed PC.
                branch_taken  = ~taken;
                branch_target = 32'hDEAD_BEE0;
                jump_target   = 32'hCAFE_F000;
                done          = 1'b1;
            end else if (rf_we) begin
                seen_rfwe = 1'b1;
            end
            @(posedge clk);
            cycles++;
            if (st == FETCH && wait_left > 0) wait_left--;
            @(negedge clk);
            imem_ready = (wait_left == 0);
            #1;
        end
        if (!done) check({tag, "/timeout"}, 32'd0, 32'd1);
        imem_ready = 1'b1;

        e = sb.pop_front();
        check({tag, "/pc"}, pc, e.pc);
        check({tag, "/instret"}, instret, e.instret);
        check({tag, "/rf_we"}, 32'(seen_rfwe), 32'(e.rfwe));
        check({tag, "/cycles"}, 32'(cycles), 32'(e.cycles));
        check({tag, "/state"}, 32'(state_o), 32'(e.end_state));
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        start  = 1'b0;
        model_instret = '0;
        tick();
        tick();
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        is_branch = 0; is_jump = 0; is_halt = 0; writes_rd = 0; branch_taken = 0;
        branch_target = '0; jump_target = '0; imem_ready = 1'b1;
        do_reset();

        check("rst/state", 32'(state_o), 32'(IDLE));
        check("rst/imem_req", 32'(imem_req), 32'd0);
        check("rst/ir_load", 32'(ir_load), 32'd0);
        check("rst/rf_we", 32'(rf_we), 32'd0);
        check("rst/halted", 32'(halted), 32'd0);
        check("rst/pc_next", pc_next, 32'h0);
        check("rst/instret", instret, 32'd0);
        check("rst/misalign", 32'(misalign_err), 32'd0);

        arst_n = 1'b1;
        tick();
        tick();
        check("idle/hold", 32'(state_o), 32'(IDLE));
        start_run();

        // Sequential run from PC 0.
        run_instr("seq0", 0, 0, 0, 1, 0, 0, 0, 0, 32'h4, 1, 1, FETCH);
        run_instr("seq1", 0, 0, 0, 1, 0, 0, 0, 0, 32'h8, 1, 1, FETCH);
        run_instr("seq2", 0, 0, 0, 1, 0, 0, 0, 0, 32'hC, 1, 1, FETCH);
        run_instr("seq3", 0, 0, 0, 1, 0, 0, 0, 0, 32'h10, 1, 1, FETCH);
        check("seq/instret4", instret, 32'd4);

        // Branches from 0x20.
        run_instr("jmp20a", 0, 1, 0, 0, 0, 32'h0, 32'h20, 0, 32'h20, 0, 1, FETCH);
        run_instr("br_tk", 1, 0, 0, 1, 1, 32'h8, 32'h0, 0, 32'h8, 1, 1, FETCH);
        run_instr("jmp20b", 0, 1, 0, 0, 0, 32'h0, 32'h20, 0, 32'h20, 0, 1, FETCH);
        run_instr("br_nt", 1, 0, 0, 0, 0, 32'h8, 32'h0, 0, 32'h24, 0, 1, FETCH);

        // Jump beats branch.
        run_instr("jmp_br", 1, 1, 0, 1, 1, 32'h200, 32'h100, 0, 32'h100, 1, 1, FETCH);

        // Fetch stall of 3 cycles.
        run_instr("stall", 0, 0, 0, 1, 0, 0, 0, 3, 32'h104, 1, 1, FETCH);

        // PC wraparound.
        run_instr("jmp_top", 0, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 1, FETCH);
        run_instr("wrap", 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 1, 1, FETCH);

        // Halt retires, then start is ignored.
        run_instr("halt", 0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0, 1, HALT);
        check("halt/halted", 32'(halted), 32'd1);
        for (int i = 0; i < 4; i++) begin
            start = i[0];
            tick();
            check("halt/stay", 32'(state_o), 32'(HALT));
        end
        start = 1'b0;
        check("halt/instret", instret, 32'd13);
        check("halt/pc", pc, 32'h0);

        // Misaligned jump.
        do_reset();
        check("rst2/instret", instret, 32'd0);
        arst_n = 1'b1;
        tick();
        start_run();
        run_instr("misal", 0, 1, 0, 1, 0, 0, 32'h102, 0, 32'h0, 0, 0, HALT);
        check("misal/err", 32'(misalign_err), 32'd1);
        check("misal/halted", 32'(halted), 32'd1);
        tick();
        check("misal/sticky", 32'(misalign_err), 32'd1);

        // Reset mid-EXECUTE discards the in-flight instruction.
        do_reset();
        check("rst3/misalign", 32'(misalign_err), 32'd0);
        arst_n = 1'b1;
        tick();
        start_run();
        run_instr("pre_rst", 0, 0, 0, 1, 0, 0, 0, 0, 32'h4, 1, 1, FETCH);
        is_branch = 0; is_jump = 0; is_halt = 0; writes_rd = 1; imem_ready = 1;
        begin
            logic reached;
            logic saw_we;
            reached = 1'b0;
            saw_we  = 1'b0;
            for (int k = 0; k < 20 && !reached; k++) begin
                if (state_o == EXECUTE) reached = 1'b1;
                else begin
                    if (rf_we) saw_we = 1'b1;
                    tick();
                end
            end
            check("mid/reach_exec", 32'(reached), 32'd1);
            arst_n = 1'b0;
            #1;
            check("mid/state", 32'(state_o), 32'(IDLE));
            check("mid/instret", instret, 32'd0);
            check("mid/pc", pc, 32'h0);
            tick();
            arst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (rf_we) saw_we = 1'b1;
                tick();
            end
            check("mid/no_rf_we", 32'(saw_we), 32'd0);
            check("mid/idle", 32'(state_o), 32'(IDLE));
            check("mid/instret2", instret, 32'd0);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
